seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter WIDTH, default 16: number of bits per frame, legal range 2..32.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset: low forces reset state immediately, release is synchronous to clock.
REQ-004 start  input  1  request to load data and begin a frame; sampled on the rising edge.
REQ-005 data  input  WIDTH  frame word; captured only on the accepting edge.
REQ-006 pause  input  1  stall: while high in SHIFT, hold out, valid and bit position.
REQ-007 out  output  1  serial bit, LSB first, registered.
REQ-008 valid  output  1  high while out carries a frame bit, registered.
REQ-009 busy  output  1  high in SHIFT and DONE states.
REQ-010 done  output  1  one-cycle pulse after the last bit, registered.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 at edge k SHALL capture data into the shift register, clear the bit counter, set out=data[0] and valid=1, and enter SHIFT.
REQ-013 In SHIFT with pause=0, each edge SHALL advance one bit, so bit i appears on out during cycle k+1+i (i = 0..WIDTH-1).
REQ-014 In SHIFT with pause=1, out, valid, the shift register and the counter SHALL hold unchanged; the frame extends by one cycle per paused edge.
REQ-015 The edge after bit WIDTH-1 has been presented, with pause=0, SHALL enter DONE with valid=0, out=0 and done=1.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE, with done back to 0.
REQ-017 start SHALL be ignored in SHIFT and DONE; data is not re-sampled mid-frame. The earliest next frame is accepted on the first edge in IDLE.
REQ-018 In IDLE, out=0, valid=0, done=0 and busy=0.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap inside a frame; the terminal compare is against WIDTH-1.
REQ-020 pause SHALL have no effect in IDLE or DONE.
REQ-021 The gap between back-to-back frames with start held high SHALL be exactly 2 cycles without valid (the DONE cycle and the accepting IDLE cycle).

Reset
REQ-022 Asserting reset low SHALL immediately force state=IDLE, shift register=0, counter=0, out=0, valid=0, busy=0 and done=0.
REQ-023 Reset mid-frame SHALL abort the frame with no done pulse; a start after release begins a fresh frame.

Structure
REQ-024 The state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) SHALL be defined as constants in the shared package seq_pkg, alongside the default WIDTH.
REQ-025 The bit counter with hold and terminal-count output SHALL be the single sub-module seq_tx_cnt; the FSM and shift register stay in seq_tx.

Verification
REQ-026 Basic frame: WIDTH=16, data=16'b0101_0111_0111_0010, pulse start at edge 0 -> out on cycles 1..16 = 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0 with valid=1; done=1 on cycle 17 only.
REQ-027 Stall: same frame, pause=1 for edges 5..7 -> bits 4..6 stretched as specified, out at bit 4 (=1) held for 4 cycles; done on cycle 20.
REQ-028 Start while busy: start=1 with data=16'hFFFF at cycle 8 of a 16'h0000 frame -> all 16 bits out=0, no restart, done on cycle 17.
REQ-029 Back-to-back: start held high, data=16'hA5A5 -> second frame's first bit on cycle 19, valid low on cycles 17-18.
REQ-030 Mid-frame reset: reset low at cycle 6 -> out=0, valid=0 and busy=0 at once; no done pulse; a start after release gives a full 16-bit frame.
REQ-031 Random: 50 random data words, each captured by a serial-to-parallel model from out/valid -> the captured word equals the sent word, with exactly one done per frame.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// default frame width and a small state decode helper.
package seq_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/seq_tx_cnt.sv
// Bit-position counter for seq_tx: cleared on frame accept, advances on
// unstalled shift edges and saturates at the last bit index.
module seq_tx_cnt
  import seq_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_r;

  // Counter register; holding at LAST_IDX keeps it from wrapping mid-frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && !last) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == LAST_IDX);

endmodule

// File: rtl/seq_tx.sv
// LSB-first serial transmitter: loads a WIDTH-bit word on start, shifts it
// out with a stall input, then pulses done for one cycle.
module seq_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             pause,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_e           state_r;
  state_e           next_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic             out_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;
  logic             out_nxt_s;
  logic             valid_nxt_s;
  logic             done_nxt_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             last_s;

  seq_tx_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (cnt_clr_s),
    .en   (cnt_en_s),
    .last (last_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = SHIFT;
        else       next_s = IDLE;
      end
      SHIFT: begin
        if (!pause && last_s) next_s = DONE;
        else                  next_s = SHIFT;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, shift register and counter controls
  always_comb begin
    shift_nxt_s = shift_r;
    out_nxt_s   = 1'b0;
    valid_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          shift_nxt_s = data;
          out_nxt_s   = data[0];
          valid_nxt_s = 1'b1;
          cnt_clr_s   = 1'b1;
        end else begin
          shift_nxt_s = shift_r;
        end
      end
      SHIFT: begin
        if (pause) begin
          out_nxt_s   = out_r;
          valid_nxt_s = valid_r;
        end else if (last_s) begin
          done_nxt_s  = 1'b1;
        end else begin
          // shift_r[0] always mirrors the bit currently on out
          shift_nxt_s = shift_r >> 1;
          out_nxt_s   = shift_r[1];
          valid_nxt_s = 1'b1;
          cnt_en_s    = 1'b1;
        end
      end
      DONE: begin
        shift_nxt_s = shift_r;
      end
      default: begin
        shift_nxt_s = shift_r;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_r <= {WIDTH{1'b0}};
      out_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      shift_r <= shift_nxt_s;
      out_r   <= out_nxt_s;
      valid_r <= valid_nxt_s;
      busy_r  <= is_busy(next_s);
      done_r  <= done_nxt_s;
    end
  end

  assign out   = out_r;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx (WIDTH=16): per-cycle expectations are queued
// as stimulus is planned and popped as the DUT produces each cycle.
module tb_seq_tx;

  localparam int W = 16;

  typedef struct packed {
    logic o;
    logic v;
    logic d;
    logic b;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data  = '0;
  logic         pause = 1'b0;
  logic         out, valid, busy, done;

  int total = 0;
  int bad   = 0;

  exp_t         exp_q[$];
  logic [W-1:0] word_q[$];

  seq_tx #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .data (data),
    .pause(pause),
    .out  (out),
    .valid(valid),
    .busy (busy),
    .done (done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic st, input logic [W-1:0] d, input logic ps);
    start = st;
    data  = d;
    pause = ps;
    @(posedge clock);
    #1;
  endtask

  // Expected trace of one frame: bit sbit shown for 1+slen cycles, then DONE, then IDLE
  task automatic push_frame(input logic [W-1:0] w, input int sbit, input int slen);
    for (int i = 0; i < W; i++) begin
      for (int r = 0; r <= ((i == sbit) ? slen : 0); r++)
        exp_q.push_back('{o: w[i], v: 1'b1, d: 1'b0, b: 1'b1});
    end
    exp_q.push_back('{o: 1'b0, v: 1'b0, d: 1'b1, b: 1'b1});
    exp_q.push_back('{o: 1'b0, v: 1'b0, d: 1'b0, b: 1'b0});
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    #1;
    total++;
    if ({out, valid, done, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold: got o/v/d/b=%b%b%b%b want 0000", out, valid, done, busy);
    end
    step(1'b1, 16'hFFFF, 1'b1);
    step(1'b1, 16'hFFFF, 1'b1);
    total++;
    if ({out, valid, done, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_start_ignored: got o/v/d/b=%b%b%b%b want 0000", out, valid, done, busy);
    end
    reset = 1'b1;
    // idle with pause high must stay quiet
    for (int c = 0; c < 3; c++) exp_q.push_back('{o: 1'b0, v: 1'b0, d: 1'b0, b: 1'b0});
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 16'hFFFF, 1'b1);
      e = exp_q.pop_front();
      total++;
      if ({out, valid, done, busy} !== {e.o, e.v, e.d, e.b}) begin
        bad++;
        $display("FAIL idle_pause c%0d: got o/v/d/b=%b%b%b%b want %b%b%b%b",
                 c, out, valid, done, busy, e.o, e.v, e.d, e.b);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int n;
    push_frame(16'b0101_0111_0111_0010, 0, 0);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      step(c == 0, 16'b0101_0111_0111_0010, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({out, valid, done, busy} !== {e.o, e.v, e.d, e.b}) begin
        bad++;
        $display("FAIL basic cycle%0d: got o/v/d/b=%b%b%b%b want %b%b%b%b",
                 c + 1, out, valid, done, busy, e.o, e.v, e.d, e.b);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int n;
    push_frame(16'b0101_0111_0111_0010, 4, 3);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      step(c == 0, 16'b0101_0111_0111_0010, (c >= 5) && (c <= 7));
      e = exp_q.pop_front();
      total++;
      if ({out, valid, done, busy} !== {e.o, e.v, e.d, e.b}) begin
        bad++;
        $display("FAIL stall cycle%0d: got o/v/d/b=%b%b%b%b want %b%b%b%b",
                 c + 1, out, valid, done, busy, e.o, e.v, e.d, e.b);
      end
    end
  endtask

  task automatic test_start_busy();
    exp_t e;
    int n;
    push_frame(16'h0000, 0, 0);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      step((c == 0) || (c == 8), (c == 8) ? 16'hFFFF : 16'h0000, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({out, valid, done, busy} !== {e.o, e.v, e.d, e.b}) begin
        bad++;
        $display("FAIL start_busy cycle%0d: got o/v/d/b=%b%b%b%b want %b%b%b%b",
                 c + 1, out, valid, done, busy, e.o, e.v, e.d, e.b);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    push_frame(16'hA5A5, 0, 0);
    push_frame(16'hA5A5, 0, 0);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      step(c < 35, 16'hA5A5, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({out, valid, done, busy} !== {e.o, e.v, e.d, e.b}) begin
        bad++;
        $display("FAIL back_to_back cycle%0d: got o/v/d/b=%b%b%b%b want %b%b%b%b",
                 c + 1, out, valid, done, busy, e.o, e.v, e.d, e.b);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int n;
    logic [W-1:0] w;
    w = 16'hC3A5;
    for (int i = 0; i < 6; i++) exp_q.push_back('{o: w[i], v: 1'b1, d: 1'b0, b: 1'b1});
    for (int c = 0; c < 6; c++) begin
      step(c == 0, w, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({out, valid, done, busy} !== {e.o, e.v, e.d, e.b}) begin
        bad++;
        $display("FAIL mid_reset_pre cycle%0d: got o/v/d/b=%b%b%b%b want %b%b%b%b",
                 c + 1, out, valid, done, busy, e.o, e.v, e.d, e.b);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if ({out, valid, done, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_async: got o/v/d/b=%b%b%b%b want 0000", out, valid, done, busy);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, w, 1'b0);
      total++;
      if ({out, valid, done, busy} !== 4'b0000) begin
        bad++;
        $display("FAIL mid_reset_held c%0d: got o/v/d/b=%b%b%b%b want 0000", c, out, valid, done, busy);
      end
    end
    reset = 1'b1;
    step(1'b0, w, 1'b0);
    total++;
    if ({out, valid, done, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_release: got o/v/d/b=%b%b%b%b want 0000", out, valid, done, busy);
    end
    push_frame(16'h8001, 0, 0);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      step(c == 0, 16'h8001, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({out, valid, done, busy} !== {e.o, e.v, e.d, e.b}) begin
        bad++;
        $display("FAIL mid_reset_fresh cycle%0d: got o/v/d/b=%b%b%b%b want %b%b%b%b",
                 c + 1, out, valid, done, busy, e.o, e.v, e.d, e.b);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w, cap, sent;
    int  nb, dones;
    logic prev_v, prev_p, p, got;
    for (int f = 0; f < 50; f++) begin
      w = W'($urandom);
      word_q.push_back(w);
      step(1'b1, w, 1'($urandom_range(0, 1)));
      cap = '0; nb = 0; dones = 0; prev_v = 1'b0; prev_p = 1'b0; got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        // a paused shift edge repeats the previous bit, so skip it
        if (valid && !(prev_v && prev_p)) begin
          cap = {out, cap[W-1:1]};
          nb++;
        end
        if (done) begin
          got = 1'b1;
          dones++;
        end else begin
          p = ($urandom_range(0, 3) == 0);
          prev_v = valid;
          prev_p = p;
          step(1'b0, 16'h0000, p);
        end
      end
      sent = word_q.pop_front();
      total++;
      if (!got) begin
        bad++;
        $display("FAIL random_timeout frame%0d: no done within budget, want done", f);
      end else if (cap !== sent || nb != W) begin
        bad++;
        $display("FAIL random_word frame%0d: got %h (%0d bits) want %h (%0d bits)", f, cap, nb, sent, W);
      end
      step(1'b0, 16'h0000, 1'b0);
      if (done) dones++;
      total++;
      if (dones != 1 || valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL random_done frame%0d: got dones=%0d valid=%b busy=%b want 1 0 0", f, dones, valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_busy();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
